// File: rtl/irq_ctrl.sv
// irq_ctrl: eight-input interrupt controller, responder side of the CPU
// interrupt handshake.
//
// It latches the peripheral request lines, applies the mask and a fixed
// priority (source 0 highest), and offers one vector to the CPU. It holds that
// vector until the CPU enters the ISR, and then waits for the iret pulse.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   addr, sel, we, re memory-mapped register access; only addr[2:1] is decoded
//   wdata / rdata     write data (bits [7:0] used) / registered read data
//   rdy               bus ready; low for the single read wait state
//   int_req[7:0]      request lines, synchronous to clk
//   int_en, in_irq    CPU global enable / CPU currently inside an ISR
//   irq_ret           one-cycle pulse when the CPU executes iret
//   irq_take          request to the CPU to enter an ISR
//   irq_vector        ISR address, valid while irq_take is high
//
// Handshake: while irq_take is high, irq_vector is stable. The CPU accepts
// the request by raising in_irq, and that cycle is the commit. If int_en
// drops first, the request is withdrawn and nothing is consumed.
//
// Register map (addr[2:1]):
//   0 PEND (read; W1C on edge-mode bits)
//   1 MASK (R/W)
//   2 MODE (R/W, 1 = rising edge)
//   3 STAT ({state, active_id})
module irq_ctrl #(
  parameter logic [15:0] VEC_BASE  = 16'h0040,
  parameter int          VEC_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rdy,
  input  logic [7:0]  int_req,
  input  logic        int_en,
  input  logic        in_irq,
  input  logic        irq_ret,
  output logic        irq_take,
  output logic [15:0] irq_vector
);

  // Encoding is visible to software through STAT[4:3].
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_REQ    = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] active_id;
  logic [7:0] req_q;
  logic [7:0] pend_edge;
  logic [7:0] mask_r;
  logic [7:0] mode_r;
  logic       rd_done;

  logic [7:0]  pending;
  logic [7:0]  cand_vec;
  logic        cand_valid;
  logic [2:0]  cand_id;
  logic [15:0] cand_id_ext;
  logic [15:0] cand_vector;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  edge_set;
  logic [7:0]  w1c_clr;
  logic [7:0]  commit_clr;
  logic        commit;
  logic [7:0]  rd_mux;

  // Only addr[2:1] and wdata[7:0] carry meaning for this block.
  logic unused_bits;
  assign unused_bits = &{addr[15:3], addr[0], wdata[15:8]};

  // Level-mode bits have no memory: they track the registered request line.
  assign pending  = (mode_r & pend_edge) | (~mode_r & req_q);
  assign cand_vec = pending & mask_r;

  always_comb begin
    cand_valid = 1'b0;
    cand_id    = 3'd0;
    // Scan from the top so the lowest index wins.
    for (int i = 7; i >= 0; i--) begin
      if (cand_vec[i]) begin
        cand_valid = 1'b1;
        cand_id    = i[2:0];
      end
    end
  end

  assign cand_id_ext = {13'd0, cand_id};
  assign cand_vector = VEC_BASE + (cand_id_ext << VEC_SHIFT);

  assign bus_rd = sel & re;
  assign bus_wr = sel & we;
  assign rdy    = ~(bus_rd & ~rd_done);

  assign commit     = (state == S_REQ) && in_irq;
  assign edge_set   = int_req & ~req_q & mode_r;
  assign w1c_clr    = (bus_wr && addr[2:1] == 2'd0) ? (wdata[7:0] & mode_r) : 8'h00;
  assign commit_clr = (commit && mode_r[active_id]) ? (8'h01 << active_id) : 8'h00;

  always_comb begin
    rd_mux = 8'h00;
    case (addr[2:1])
      2'd0: rd_mux = pending;
      2'd1: rd_mux = mask_r;
      2'd2: rd_mux = mode_r;
      2'd3: rd_mux = {3'b000, state, active_id};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      active_id  <= 3'd0;
      req_q      <= 8'h00;
      pend_edge  <= 8'h00;
      mask_r     <= 8'h00;
      mode_r     <= 8'hFF;
      rd_done    <= 1'b0;
      rdata      <= 16'h0000;
      irq_take   <= 1'b0;
      irq_vector <= VEC_BASE;
    end else begin
      req_q <= int_req;
      // A new edge wins over a same-cycle clear.
      pend_edge <= (pend_edge & ~(w1c_clr | commit_clr)) | edge_set;

      if (bus_wr && addr[2:1] == 2'd1) mask_r <= wdata[7:0];
      if (bus_wr && addr[2:1] == 2'd2) mode_r <= wdata[7:0];

      // Capture the read data in the strobe cycle. It then holds until the next read.
      rd_done <= bus_rd;
      if (bus_rd && !rd_done) rdata <= {8'h00, rd_mux};

      case (state)
        S_IDLE: begin
          if (cand_valid && int_en && !in_irq) begin
            active_id  <= cand_id;
            irq_vector <= cand_vector;
            irq_take   <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          // The vector is frozen here. Later arrivals wait in pending.
          if (in_irq) begin
            irq_take <= 1'b0;
            state    <= S_ACTIVE;
          end else if (!int_en) begin
            irq_take <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_ACTIVE: begin
          if (irq_ret) state <= S_IDLE;
        end
        default: begin
          irq_take <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
